// File: rtl/inst_fifo_if.sv
// Fetch/issue handshake bundle for the instruction queue.
// master: fetch+issue side (pushes, pops, flush); slave: the queue.
interface inst_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 99
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic [WIDTH-1:0] fifo_w_data_1;
    logic             fifo_w_ena_1;
    logic [WIDTH-1:0] fifo_w_data_2;
    logic             fifo_w_ena_2;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_r_data_1;
    logic             fifo_r_data_1_ok;
    logic [WIDTH-1:0] fifo_r_data_2;
    logic             fifo_r_data_2_ok;
    logic             p_data_1;
    logic             p_data_2;
    logic [CW-1:0]    fifo_count;

    modport master (
        output flush,
        output fifo_w_data_1,
        output fifo_w_ena_1,
        output fifo_w_data_2,
        output fifo_w_ena_2,
        output p_data_1,
        output p_data_2,
        input  fifo_full,
        input  fifo_r_data_1,
        input  fifo_r_data_1_ok,
        input  fifo_r_data_2,
        input  fifo_r_data_2_ok,
        input  fifo_count
    );

    modport slave (
        input  flush,
        input  fifo_w_data_1,
        input  fifo_w_ena_1,
        input  fifo_w_data_2,
        input  fifo_w_ena_2,
        input  p_data_1,
        input  p_data_2,
        output fifo_full,
        output fifo_r_data_1,
        output fifo_r_data_1_ok,
        output fifo_r_data_2,
        output fifo_r_data_2_ok,
        output fifo_count
    );
endinterface

// File: rtl/inst_fifo.sv
// Dual-port in-order instruction queue between fetch and issue.
// Ports: clk, rst (async, active-low), bus (inst_fifo_if.slave):
//   up to 2 pushes/cycle, head/head+1 presented with ok flags,
//   0/1/2 pops/cycle, flush, full flag and occupancy count.
module inst_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 99
) (
    input  logic         clk,
    input  logic         rst,
    inst_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    npush;
    logic [1:0]    req_pop;
    logic [1:0]    npop;
    logic [CW-1:0] free;
    logic          accept;
    logic          wr_ok;
    logic [AW-1:0] tail_n;
    logic [AW-1:0] head_n;
    logic [WIDTH-1:0] wdata0;

    // Free space is judged on the registered count only, so a
    // same-cycle pop never makes room for a push.
    assign npush  = {1'b0, bus.fifo_w_ena_1}
                  + {1'b0, bus.fifo_w_ena_2};
    assign free   = CW'(DEPTH) - count_q;
    assign accept = CW'(npush) <= free;
    assign wr_ok  = accept && !bus.flush;

    assign req_pop = {bus.p_data_1 & bus.p_data_2,
                      bus.p_data_1 & ~bus.p_data_2};

    // Clamp the pop request to what is actually held.
    always_comb begin
        npop = 2'd0;
        unique case (1'b1)
            (count_q == '0):      npop = 2'd0;
            (count_q == CW'(1)):  npop = {1'b0, |req_pop};
            default:              npop = req_pop;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(npop);
            if (accept) begin
                tail_d = tail_q + AW'(npush);
            end
            count_d = count_q - CW'(npop)
                    + (accept ? CW'(npush) : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Pushes are compacted: a lone second-port push lands at tail.
    assign tail_n = tail_q + AW'(1);
    assign wdata0 = bus.fifo_w_ena_1 ? bus.fifo_w_data_1
                                     : bus.fifo_w_data_2;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (bus.fifo_w_ena_1 || bus.fifo_w_ena_2) begin
                mem_q[tail_q] <= wdata0;
            end
            if (bus.fifo_w_ena_1 && bus.fifo_w_ena_2) begin
                mem_q[tail_n] <= bus.fifo_w_data_2;
            end
        end
    end

    // Outputs depend on registered state only; storage is never
    // reset, so stale entries are masked by the count.
    assign head_n = head_q + AW'(1);

    assign bus.fifo_r_data_1_ok = count_q >= CW'(1);
    assign bus.fifo_r_data_2_ok = count_q >= CW'(2);

    assign bus.fifo_r_data_1 = bus.fifo_r_data_1_ok
                             ? mem_q[head_q] : '0;
    assign bus.fifo_r_data_2 = bus.fifo_r_data_2_ok
                             ? mem_q[head_n] : '0;

    assign bus.fifo_full  = count_q > CW'(DEPTH - 2);
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboard bench for inst_fifo: directed pushes/pops/flush/reset,
// with a negedge monitor comparing popped entries in order.
module tb_inst_fifo;
    typedef logic [98:0] ent_t;

    logic clk;
    logic rst;

    inst_fifo_if #(.DEPTH(16), .WIDTH(99)) bus ();

    inst_fifo #(.DEPTH(16), .WIDTH(99)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk;
    int   n_fail;
    ent_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t ent(input logic [31:0] pc);
        return {1'b0, 32'h0, 2'b00, pc, pc ^ 32'h1357_9bdf};
    endfunction

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic idle();
        bus.flush         = 1'b0;
        bus.fifo_w_ena_1  = 1'b0;
        bus.fifo_w_ena_2  = 1'b0;
        bus.fifo_w_data_1 = '0;
        bus.fifo_w_data_2 = '0;
        bus.p_data_1      = 1'b0;
        bus.p_data_2      = 1'b0;
    endtask

    task automatic cyc(input logic e1, input ent_t d1,
                       input logic e2, input ent_t d2,
                       input logic p1, input logic p2,
                       input logic fl);
        bus.fifo_w_ena_1  = e1;
        bus.fifo_w_data_1 = d1;
        bus.fifo_w_ena_2  = e2;
        bus.fifo_w_data_2 = d2;
        bus.p_data_1      = p1;
        bus.p_data_2      = p2;
        bus.flush         = fl;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push2(input ent_t a, input ent_t b);
        exp_q.push_back(a);
        exp_q.push_back(b);
        cyc(1'b1, a, 1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push1(input ent_t a);
        exp_q.push_back(a);
        cyc(1'b1, a, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop(input int n);
        cyc(1'b0, '0, 1'b0, '0, 1'b1, n == 2, 1'b0);
    endtask

    // Monitor: whenever issue pops a valid slot, that slot must
    // carry the next expected entry in program order.
    always @(negedge clk) begin
        if (rst && !bus.flush && bus.p_data_1
            && bus.fifo_r_data_1_ok) begin
            if (exp_q.size() == 0) begin
                chk("mon_underflow", 1, 0);
            end else begin
                chk("mon_head", bus.fifo_r_data_1,
                    exp_q.pop_front());
            end
            if (bus.p_data_2 && bus.fifo_r_data_2_ok) begin
                if (exp_q.size() == 0) begin
                    chk("mon_underflow2", 1, 0);
                end else begin
                    chk("mon_next", bus.fifo_r_data_2,
                        exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        ent_t a, b, c, e;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle();
        #2;
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_full", bus.fifo_full, 0);
        chk("rst_ok1", bus.fifo_r_data_1_ok, 0);
        chk("rst_ok2", bus.fifo_r_data_2_ok, 0);
        chk("rst_rd1", bus.fifo_r_data_1, 0);
        chk("rst_rd2", bus.fifo_r_data_2, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Dual push, both visible next cycle.
        a = ent(32'hBFC0_0000);
        b = ent(32'hBFC0_0004);
        push2(a, b);
        chk("ab_rd1", bus.fifo_r_data_1, a);
        chk("ab_rd2", bus.fifo_r_data_2, b);
        chk("ab_ok1", bus.fifo_r_data_1_ok, 1);
        chk("ab_ok2", bus.fifo_r_data_2_ok, 1);
        chk("ab_count", bus.fifo_count, 2);
        pop(2);
        chk("ab_drain", bus.fifo_count, 0);

        // Lone second-port push is compacted to the head.
        c = ent(32'hBFC0_0008);
        exp_q.push_back(c);
        cyc(1'b0, '0, 1'b1, c, 1'b0, 1'b0, 1'b0);
        chk("c_rd1", bus.fifo_r_data_1, c);
        chk("c_ok1", bus.fifo_r_data_1_ok, 1);
        chk("c_ok2", bus.fifo_r_data_2_ok, 0);
        chk("c_rd2", bus.fifo_r_data_2, 0);
        chk("c_count", bus.fifo_count, 1);
        // p_data_2 with one entry pops only the head.
        pop(2);
        chk("c_drain", bus.fifo_count, 0);

        // Fill to 15, full, drop a push, pop 2.
        for (int i = 0; i < 7; i++) begin
            push2(ent(32'h1000 + 8 * i),
                  ent(32'h1004 + 8 * i));
        end
        chk("fill14_full", bus.fifo_full, 0);
        push1(ent(32'h1100));
        chk("fill_count", bus.fifo_count, 15);
        chk("fill_full", bus.fifo_full, 1);
        cyc(1'b1, ent(32'hDEAD), 1'b1, ent(32'hBEEF),
            1'b0, 1'b0, 1'b0);
        chk("drop_count", bus.fifo_count, 15);
        chk("drop_full", bus.fifo_full, 1);
        pop(2);
        chk("pop13_count", bus.fifo_count, 13);
        chk("pop13_full", bus.fifo_full, 0);
        for (int i = 0; i < 6; i++) pop(2);
        pop(1);
        chk("fill_drain", bus.fifo_count, 0);
        chk("fill_sb", exp_q.size(), 0);

        // Pop 2 and push 2 in one cycle at count 3.
        a = ent(32'h2000);
        b = ent(32'h2004);
        c = ent(32'h2008);
        push2(a, b);
        push1(c);
        chk("pp_pre", bus.fifo_count, 3);
        a = ent(32'h200C);
        b = ent(32'h2010);
        exp_q.push_back(a);
        exp_q.push_back(b);
        cyc(1'b1, a, 1'b1, b, 1'b1, 1'b1, 1'b0);
        chk("pp_count", bus.fifo_count, 3);
        chk("pp_rd1", bus.fifo_r_data_1, c);
        chk("pp_rd2", bus.fifo_r_data_2, a);
        pop(2);
        pop(1);
        chk("pp_drain", bus.fifo_count, 0);

        // Move head to 15, then straddle the wrap.
        for (int i = 0; i < 4; i++) begin
            push2(ent(32'h3000 + 8 * i),
                  ent(32'h3004 + 8 * i));
        end
        for (int i = 0; i < 4; i++) pop(2);
        a = ent(32'h4000);
        b = ent(32'h4004);
        push2(a, b);
        chk("wrap_rd1", bus.fifo_r_data_1, a);
        chk("wrap_rd2", bus.fifo_r_data_2, b);
        pop(2);
        chk("wrap_count", bus.fifo_count, 0);
        c = ent(32'h4008);
        push1(c);
        chk("wrap_next", bus.fifo_r_data_1, c);
        pop(1);

        // Flush with pushes and pops active at count 9.
        for (int i = 0; i < 4; i++) begin
            push2(ent(32'h5000 + 8 * i),
                  ent(32'h5004 + 8 * i));
        end
        push1(ent(32'h5100));
        chk("fl_pre", bus.fifo_count, 9);
        cyc(1'b1, ent(32'h5200), 1'b1, ent(32'h5204),
            1'b1, 1'b1, 1'b1);
        exp_q.delete();
        chk("fl_count", bus.fifo_count, 0);
        chk("fl_ok1", bus.fifo_r_data_1_ok, 0);
        chk("fl_ok2", bus.fifo_r_data_2_ok, 0);
        chk("fl_rd1", bus.fifo_r_data_1, 0);
        chk("fl_rd2", bus.fifo_r_data_2, 0);
        a = ent(32'h6000);
        b = ent(32'h6004);
        push2(a, b);
        chk("fl_after", bus.fifo_r_data_1, a);

        // Asynchronous reset mid-cycle, no clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("ar_count", bus.fifo_count, 0);
        chk("ar_ok1", bus.fifo_r_data_1_ok, 0);
        chk("ar_ok2", bus.fifo_r_data_2_ok, 0);
        chk("ar_rd1", bus.fifo_r_data_1, 0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        e = ent(32'h7000);
        push1(e);
        chk("ar_push", bus.fifo_r_data_1, e);
        pop(1);
        chk("end_count", bus.fifo_count, 0);
        chk("end_sb", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
